// File: rtl/warmboot_ctrl.sv
// warmboot_ctrl: sequences the fabric WARMBOOT primitive.
// Requesters are arbitrated round-robin while idle, and the requested slot is
// range-checked. A valid slot arms an abortable delay, then drives a timed
// BOOT pulse with SLOT held stable. After that the block parks in HOLD until
// the fabric reloads.
// Optional build macro WARMBOOT_CTRL_WDT_EN adds an idle watchdog. When it
// expires, the watchdog forces a boot into WDT_SLOT.
module warmboot_ctrl #(
  parameter int NUM_REQ    = 2,
  parameter int SLOT_W     = 4,
  parameter int NUM_SLOTS  = 16,
  parameter int ARM_CYCLES = 16,
  parameter int BOOT_PULSE = 4,
`ifdef WARMBOOT_CTRL_WDT_EN
  parameter int WDT_CYCLES = 1024,
  parameter int WDT_SLOT   = 0,
`endif
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*SLOT_W-1:0] req_slot_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      abort_i,
  output logic [SLOT_W-1:0]         slot_o,
  output logic                      boot_o,
  output logic                      busy_o,
  output logic                      err_o,
`ifdef WARMBOOT_CTRL_WDT_EN
  input  logic                      wdt_kick_i,
  output logic                      wdt_fired_o,
`endif
  output logic [ID_W-1:0]           grant_id_o
);

  localparam int CNT_MAX = (ARM_CYCLES > BOOT_PULSE) ? ARM_CYCLES : BOOT_PULSE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ARM, FIRE, HOLD} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ID_W-1:0]     rr_ptr;

  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [NUM_REQ-1:0]  win_oh;
  logic [SLOT_W-1:0]   win_slot;
  logic                slot_ok;
  logic                accept;
  logic                wdt_due;
  logic [ID_W-1:0]     rr_next;

  // Round-robin pick: first valid at or above rr_ptr, else first valid from 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    win_slot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid_i[i] && (i >= int'(rr_ptr))) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
        win_oh[i] = 1'b1;
        win_slot  = req_slot_i[i*SLOT_W +: SLOT_W];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid_i[i]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
        win_oh[i] = 1'b1;
        win_slot  = req_slot_i[i*SLOT_W +: SLOT_W];
      end
    end
  end

  // Requests are only offered in IDLE, and not when the watchdog takes the cycle.
  always_comb begin
    req_ready_o = '0;
    if ((state == IDLE) && !wdt_due && win_found)
      req_ready_o = win_oh;
  end

  assign accept  = |req_ready_o;
  assign slot_ok = int'(win_slot) < NUM_SLOTS;
  assign rr_next = (win_idx == LAST_ID) ? '0 : win_idx + ID_W'(1);

`ifdef WARMBOOT_CTRL_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_cnt;

  assign wdt_due = (state == IDLE) && (wdt_cnt == '0);

  // Watchdog down-counter: a kick reloads it; it only drains while idle.
  always_ff @(posedge clk) begin
    if (reset || wdt_kick_i)
      wdt_cnt <= WDT_W'(WDT_CYCLES);
    else if ((state == IDLE) && (wdt_cnt != '0))
      wdt_cnt <= wdt_cnt - WDT_W'(1);
  end
`else
  assign wdt_due = 1'b0;
`endif

  // Main sequencer: IDLE -> ARM -> FIRE -> HOLD, with abort back to IDLE from ARM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      slot_o     <= '0;
      boot_o     <= 1'b0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
      grant_id_o <= '0;
`ifdef WARMBOOT_CTRL_WDT_EN
      wdt_fired_o <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (wdt_due) begin
`ifdef WARMBOOT_CTRL_WDT_EN
            slot_o      <= SLOT_W'(WDT_SLOT);
            wdt_fired_o <= 1'b1;
`endif
            state  <= ARM;
            busy_o <= 1'b1;
            cnt    <= CNT_W'(ARM_CYCLES - 1);
          end else if (accept) begin
            grant_id_o <= win_idx;
            rr_ptr     <= rr_next;
            if (slot_ok) begin
              slot_o <= win_slot;
              err_o  <= 1'b0;
              state  <= ARM;
              busy_o <= 1'b1;
              cnt    <= CNT_W'(ARM_CYCLES - 1);
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ARM: begin
          if (abort_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (cnt == '0) begin
            state  <= FIRE;
            boot_o <= 1'b1;
            cnt    <= CNT_W'(BOOT_PULSE - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIRE: begin
          if (cnt == '0) begin
            state  <= HOLD;
            boot_o <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          state <= HOLD;
        end
        default: begin
          state  <= IDLE;
          boot_o <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
